// File: rtl/sync_fifo_buffer.sv
// ---------------------------------------------------------------------------
// sync_fifo_buffer
//   Single-clock FIFO storage stage. Words written on the write port come back
//   in order on the read port one cycle after an accepted read. The stage
//   reports occupancy and full/empty flags, and pulses flags for rejected
//   requests. Storage is a plain array with a registered read so it maps onto
//   block RAM. The array is never reset; only pointers, count and outputs are.
//
// Ports
//   CLK        in   1        clock, all logic on the rising edge
//   reset      in   1        synchronous reset, active-high
//   wr_en      in   1        write request
//   din        in   WIDTH    write data, sampled when a write is accepted
//   rd_en      in   1        read request
//   dout       out  WIDTH    registered read data, holds when no read
//   dout_valid out  1        one-cycle pulse: dout carries a newly read word
//   full       out  1        count == DEPTH
//   empty      out  1        count == 0
//   count      out  AW+1     occupancy, 0..DEPTH
//   overflow   out  1        one-cycle pulse: write dropped (full, no read)
//   underflow  out  1        one-cycle pulse: read rejected (empty)
// ---------------------------------------------------------------------------
module sync_fifo_buffer #(
    parameter int WIDTH = 8,
    parameter int AW    = 5
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wptr_reg;
    logic [AW-1:0]    rptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             full_reg;
    logic             empty_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             dout_valid_reg;
    logic             overflow_reg;
    logic             underflow_reg;

    logic             rd_ok;
    logic             wr_ok;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a
    // write when a read is accepted alongside it.
    assign rd_ok = rd_en & ~empty_reg;
    assign wr_ok = wr_en & (~full_reg | rd_ok);

    always_comb begin
        count_next = count_reg;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage array: no reset so it can be inferred as block RAM. Reset still
    // blocks the write so a reset cycle leaves no side effects.
    always_ff @(posedge CLK) begin
        if (!reset && wr_ok) begin
            mem[wptr_reg] <= din;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            count_reg      <= '0;
            full_reg       <= 1'b0;
            empty_reg      <= 1'b1;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            // Pointers wrap naturally at DEPTH because they are AW bits wide.
            if (wr_ok) begin
                wptr_reg <= wptr_reg + AW'(1);
            end
            // When full, rptr == wptr; the non-blocking read returns the old
            // word before the same-cycle write replaces it.
            if (rd_ok) begin
                dout_reg <= mem[rptr_reg];
                rptr_reg <= rptr_reg + AW'(1);
            end
            count_reg      <= count_next;
            // Flags come from the next count so they line up with count.
            full_reg       <= (count_next == (AW+1)'(DEPTH));
            empty_reg      <= (count_next == '0);
            dout_valid_reg <= rd_ok;
            overflow_reg   <= wr_en & ~wr_ok;
            underflow_reg  <= rd_en & empty_reg;
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign full       = full_reg;
    assign empty      = empty_reg;
    assign count      = count_reg;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;

endmodule
